host_cmd_issuer: RTL and testbench

Host-side command encoder and issuer for the NPU control path. Accepts structured commands (load, store, move, fetch, exec) on a valid/ready interface, buffers them in a small FIFO, packs each into the 32-bit `h2f_io` command word, and pulses `h2f_write` only when the control unit reports idle via `isrunning`. Sits between the HPS/bridge logic and `ctrl_unit`. It drives the opposite end of the `h2f_io`/`h2f_write`/`isrunning` protocol that `ctrl_unit` decodes.

---
 rtl/host_cmd_issuer_pkg.sv | 41 ++++
 rtl/host_cmd_issuer_fifo.sv | 42 ++++
 rtl/host_cmd_issuer.sv | 107 ++++++++++
 tb/tb_host_cmd_issuer.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/host_cmd_issuer_pkg.sv
// pkg_host_cmd: shared definitions for the host <-> ctrl_unit h2f_io command protocol.
// Contents: opcode enum, field widths, issuer FSM states, legality check and the
// command-word encoder (reusable by ctrl_unit benches).
package pkg_host_cmd;
    localparam int OP_W   = 3;
    localparam int RF_W   = 10;
    localparam int EXT_W  = 24;
    localparam int LINE_W = 8;
    localparam int EU_W   = 5;
    localparam int WORD_W = 32;
    typedef enum logic [OP_W-1:0] {
        OP_LOAD  = 3'd0,
        OP_STORE = 3'd1,
        OP_MOVE  = 3'd2,
        OP_FETCH = 3'd3,
        OP_EXEC  = 3'd4
    } host_cmd_op_e;
    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_GAP, S_WAIT_DONE} host_cmd_state_e;
    function automatic logic host_cmd_legal(input logic [OP_W-1:0] op);
        return op <= OP_EXEC;
    endfunction
    function automatic logic [WORD_W-1:0] host_cmd_encode(
        input logic [OP_W-1:0]   op,
        input logic [RF_W-1:0]   rf,
        input logic [RF_W-1:0]   rf2,
        input logic [EXT_W-1:0]  ext,
        input logic [LINE_W-1:0] line,
        input logic [EU_W-1:0]   eu
    );
        logic [WORD_W-1:0] w;
        case (op)
            OP_LOAD:  w = {2'b00, rf[8:0], ext[12:0], line};
            OP_STORE: w = {2'b01, rf[8:0], ext[12:0], line};
            OP_MOVE:  w = {2'b10, rf, rf2, 2'b00, line};
            OP_FETCH: w = {2'b11, 1'b0, eu, ext};
            OP_EXEC:  w = {2'b11, 1'b1, eu, 24'h0};
            default:  w = '0;
        endcase
        return w;
    endfunction
endpackage

// File: rtl/host_cmd_issuer_fifo.sv
// host_cmd_fifo: synchronous DEPTH x WIDTH FIFO with show-ahead head output.
// Ports: clk, rst_n (async, active-low; discards contents), push/din, pop/dout,
// full, empty. Push when full and pop when empty are ignored.
module host_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr, rptr;
    logic [AW:0]      count;
    logic             do_push, do_pop;
    assign full    = count == DEPTH_C;
    assign empty   = count == '0;
    assign dout    = mem[rptr];
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            wptr  <= wptr + AW'(do_push);
            rptr  <= rptr + AW'(do_pop);
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end
    always_ff @(posedge clk) begin
        if (do_push) mem[wptr] <= din;
    end
endmodule

// File: rtl/host_cmd_issuer.sv
// host_cmd_issuer: encodes host commands into 32-bit h2f_io words, queues them and
// issues each with a one-cycle h2f_write strobe once ctrl_unit reports idle.
// Ports: clk, rst_n (async, active-low); cmd_valid/cmd_ready handshake with
// cmd_op, cmd_rf_addr, cmd_rf_addr2, cmd_ext_addr, cmd_line_num, cmd_eu_id;
// h2f_io/h2f_write to ctrl_unit, isrunning from it; busy, issued_cnt,
// err_illegal, err_timeout status.
// Build option: define HOST_CMD_ISSUER_TIMEOUT_EN to abort a command whose busy
// phase exceeds TIMEOUT cycles (sets err_timeout); otherwise err_timeout is 0.
module host_cmd_issuer
    import pkg_host_cmd::*;
#(
    parameter int DEPTH     = 4,
    parameter int ISSUE_GAP = 2,
    parameter int TIMEOUT   = 4096
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [OP_W-1:0]   cmd_op,
    input  logic [RF_W-1:0]   cmd_rf_addr,
    input  logic [RF_W-1:0]   cmd_rf_addr2,
    input  logic [EXT_W-1:0]  cmd_ext_addr,
    input  logic [LINE_W-1:0] cmd_line_num,
    input  logic [EU_W-1:0]   cmd_eu_id,
    output logic [WORD_W-1:0] h2f_io,
    output logic              h2f_write,
    input  logic              isrunning,
    output logic              busy,
    output logic [15:0]       issued_cnt,
    output logic              err_illegal,
    output logic              err_timeout
);
    localparam int CW = $clog2(TIMEOUT + ISSUE_GAP + 1);
    host_cmd_state_e   state, state_nxt;
    logic              rdy_en, full, empty, accept, push, issue, timeout;
    logic [WORD_W-1:0] head;
    logic [CW-1:0]     cnt;
    // rdy_en keeps cmd_ready low in reset and lifts it on the first edge after.
    assign cmd_ready = rdy_en & ~full;
    assign accept    = cmd_valid & cmd_ready;
    assign push      = accept & host_cmd_legal(cmd_op);
    host_cmd_fifo #(.DEPTH(DEPTH), .WIDTH(WORD_W)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .din   (host_cmd_encode(cmd_op, cmd_rf_addr, cmd_rf_addr2, cmd_ext_addr, cmd_line_num, cmd_eu_id)),
        .pop   (issue),
        .dout  (head),
        .full  (full),
        .empty (empty)
    );
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:      state_nxt = (!empty && !isrunning) ? S_ISSUE : S_IDLE;
            S_ISSUE:     state_nxt = S_GAP;
            S_GAP:       state_nxt = timeout ? S_IDLE : (cnt == CW'(ISSUE_GAP - 1)) ? S_WAIT_DONE : S_GAP;
            S_WAIT_DONE: state_nxt = (timeout || !isrunning) ? S_IDLE : S_WAIT_DONE;
            default:     state_nxt = S_IDLE;
        endcase
    end
    always_comb begin
        issue = state == S_ISSUE;
        busy  = !empty || state != S_IDLE;
    end
    // One counter serves both the post-issue blanking window and the busy timeout;
    // it restarts at every issue so GAP always sees it from zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt <= '0;
        else if (issue) cnt <= '0;
        else if (state == S_GAP || state == S_WAIT_DONE) cnt <= cnt + 1'b1;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdy_en      <= 1'b0;
            h2f_io      <= '0;
            h2f_write   <= 1'b0;
            issued_cnt  <= '0;
            err_illegal <= 1'b0;
        end else begin
            rdy_en      <= 1'b1;
            h2f_write   <= issue;
            err_illegal <= err_illegal | (accept & ~host_cmd_legal(cmd_op));
            if (issue) begin
                h2f_io     <= head;
                issued_cnt <= issued_cnt + 16'd1;
            end
        end
    end
`ifdef HOST_CMD_ISSUER_TIMEOUT_EN
    logic err_to_q;
    assign timeout     = (state == S_GAP || state == S_WAIT_DONE) && cnt == CW'(TIMEOUT - 1);
    assign err_timeout = err_to_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) err_to_q <= 1'b0;
        else        err_to_q <= err_to_q | timeout;
    end
`else
    assign timeout     = 1'b0;
    assign err_timeout = 1'b0;
`endif
endmodule

// File: tb/tb_host_cmd_issuer.sv
// tb_host_cmd_issuer: directed and randomized bench for host_cmd_issuer with a
// queue-based reference model of the command words and issue rules.
module tb_host_cmd_issuer;
    localparam int DEPTH = 4;
    localparam int GAP   = 2;
    logic        clk = 1'b0, rst_n = 1'b0;
    logic        cmd_valid = 1'b0, isrunning = 1'b0;
    logic [2:0]  cmd_op = '0;
    logic [9:0]  cmd_rf_addr = '0, cmd_rf_addr2 = '0;
    logic [23:0] cmd_ext_addr = '0;
    logic [7:0]  cmd_line_num = '0;
    logic [4:0]  cmd_eu_id = '0;
    logic        cmd_ready, h2f_write, busy, err_illegal, err_timeout;
    logic [31:0] h2f_io;
    logic [15:0] issued_cnt;
    always #5 clk = ~clk;
    host_cmd_issuer #(.DEPTH(DEPTH), .ISSUE_GAP(GAP), .TIMEOUT(4096)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_op       (cmd_op),
        .cmd_rf_addr  (cmd_rf_addr),
        .cmd_rf_addr2 (cmd_rf_addr2),
        .cmd_ext_addr (cmd_ext_addr),
        .cmd_line_num (cmd_line_num),
        .cmd_eu_id    (cmd_eu_id),
        .h2f_io       (h2f_io),
        .h2f_write    (h2f_write),
        .isrunning    (isrunning),
        .busy         (busy),
        .issued_cnt   (issued_cnt),
        .err_illegal  (err_illegal),
        .err_timeout  (err_timeout)
    );
    int          n_cmp = 0, n_err = 0;
    int          cyc = 0, nwr = 0, n_iss = 0, last_wr = -1000, push_cyc = 0;
    bit          rnd_done = 1'b0;
    bit          ir_at [0:99999];
    int          wr_hist [$];
    logic [31:0] exp_q [$];
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask
    // Reference packing computed arithmetically from the field layout.
    function automatic logic [31:0] enc_ref(input logic [2:0] op, input logic [9:0] rf, input logic [9:0] rf2,
                                            input logic [23:0] ext, input logic [7:0] line, input logic [4:0] eu);
        logic [31:0] rf9, ext13;
        rf9   = 32'(rf) % 512;
        ext13 = 32'(ext) % 8192;
        case (op)
            3'd0:    return (rf9 << 21) + (ext13 << 8) + 32'(line);
            3'd1:    return 32'h4000_0000 + (rf9 << 21) + (ext13 << 8) + 32'(line);
            3'd2:    return 32'h8000_0000 + (32'(rf) << 20) + (32'(rf2) << 10) + 32'(line);
            3'd3:    return 32'hC000_0000 + (32'(eu) << 24) + 32'(ext);
            3'd4:    return 32'hE000_0000 + (32'(eu) << 24);
            default: return 32'h0;
        endcase
    endfunction
    // Cycle counter, isrunning history and write monitor/scoreboard.
    always @(posedge clk) begin
        cyc++;
        if (cyc < 100000) ir_at[cyc] = isrunning;
        #1;
        if (rst_n && h2f_write) begin
            chk("issue_while_running", 32'(ir_at[cyc-1]), 0);
            if (last_wr >= 0) chk("write_spacing_ok", 32'(cyc - last_wr >= GAP + 3), 1);
            if (exp_q.size() == 0) chk("spurious_write", 32'(h2f_write), 0);
            else chk("h2f_io_word", h2f_io, exp_q.pop_front());
            last_wr = cyc;
            wr_hist.push_back(cyc);
            nwr++;
            n_iss++;
        end
    end
    task automatic send(input logic [2:0] op, input logic [9:0] rf, input logic [9:0] rf2,
                        input logic [23:0] ext, input logic [7:0] line, input logic [4:0] eu);
        int n = 0;
        cmd_op = op; cmd_rf_addr = rf; cmd_rf_addr2 = rf2;
        cmd_ext_addr = ext; cmd_line_num = line; cmd_eu_id = eu;
        cmd_valid = 1'b1;
        while (!cmd_ready && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) begin
            chk("ready_wait", 32'(cmd_ready), 1);
            cmd_valid = 1'b0;
            return;
        end
        @(negedge clk);
        cmd_valid = 1'b0;
        push_cyc = cyc;
        if (op <= 3'd4) exp_q.push_back(enc_ref(op, rf, rf2, ext, line, eu));
    endtask
    task automatic send_rand(input int max_op);
        send(3'($urandom_range(0, max_op)), 10'($urandom), 10'($urandom), 24'($urandom), 8'($urandom), 5'($urandom));
    endtask
    task automatic wait_wr(input int target);
        int n = 0;
        while (nwr < target && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("write_seen", 32'(nwr >= target), 1);
    endtask
    initial begin
        #900000;
        $display("FAIL watchdog: run did not finish, compared %0d", n_cmp);
        $fatal(1, "watchdog");
    end
    initial begin
        int p, f;
        repeat (3) @(negedge clk);
        chk("rst_cmd_ready", 32'(cmd_ready), 0);
        chk("rst_h2f_write", 32'(h2f_write), 0);
        chk("rst_h2f_io", h2f_io, 0);
        chk("rst_issued_cnt", 32'(issued_cnt), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_err", 32'({err_illegal, err_timeout}), 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_rst", 32'(cmd_ready), 1);
        // Single LOAD with idle control unit: push edge +2 gives the strobe.
        send(3'd0, 10'd0, 10'd0, 24'h1234, 8'd166, 5'd0);
        p = push_cyc;
        wait_wr(1);
        chk("load_latency", 32'(last_wr - p), 2);
        repeat (3) @(negedge clk);
        chk("load_word_held", h2f_io, 32'h0012_34A6);
        chk("write_is_pulse", 32'(h2f_write), 0);
        chk("issued_one", 32'(issued_cnt), 1);
        repeat (5) @(negedge clk);
        // MOVE then EXEC back to back: minimum spacing between strobes.
        send(3'd2, 10'd167, 10'h200, 24'h0, 8'd166, 5'd0);
        p = push_cyc;
        send(3'd4, 10'd0, 10'd0, 24'h0, 8'd0, 5'd17);
        wait_wr(3);
        chk("move_latency", 32'(wr_hist[1] - p), 2);
        chk("b2b_spacing", 32'(wr_hist[2] - wr_hist[1]), GAP + 3);
        chk("exec_word", h2f_io, 32'hF100_0000);
        repeat (8) @(negedge clk);
        // FETCH, then the control unit stays busy while 3 more queue up.
        send(3'd3, 10'd0, 10'd0, 24'h345678, 8'd0, 5'd17);
        wait_wr(4);
        chk("fetch_word", h2f_io, 32'hD134_5678);
        isrunning = 1'b1;
        repeat (3) send_rand(2);
        repeat (50) @(negedge clk);
        chk("stall_no_write", 32'(nwr), 4);
        chk("stall_busy", 32'(busy), 1);
        isrunning = 1'b0;
        f = cyc;
        wait_wr(5);
        chk("resume_latency", 32'(wr_hist[4] - f), 3);
        wait_wr(7);
        repeat (10) @(negedge clk);
        chk("idle_not_busy", 32'(busy), 0);
        // Fill the FIFO while stalled in IDLE, then one more once space frees.
        isrunning = 1'b1;
        repeat (DEPTH) send_rand(4);
        chk("full_ready_low", 32'(cmd_ready), 0);
        chk("full_no_write", 32'(nwr), 7);
        isrunning = 1'b0;
        send_rand(4);
        wait_wr(12);
        repeat (10) @(negedge clk);
        chk("full_drained", 32'(exp_q.size()), 0);
        chk("ready_restored", 32'(cmd_ready), 1);
        chk("issued_twelve", 32'(issued_cnt), 12);
        // Illegal opcode: accepted, dropped, sticky error.
        chk("err_illegal_clear", 32'(err_illegal), 0);
        send(3'd6, 10'd5, 10'd6, 24'h7, 8'd8, 5'd9);
        repeat (20) @(negedge clk);
        chk("illegal_no_write", 32'(nwr), 12);
        chk("err_illegal_set", 32'(err_illegal), 1);
        chk("illegal_not_busy", 32'(busy), 0);
        // Reset during GAP with commands still queued.
        send(3'd1, 10'h1FF, 10'd0, 24'h1FFF, 8'hFF, 5'd0);
        send(3'd0, 10'd3, 10'd0, 24'h0ABC, 8'd1, 5'd0);
        send(3'd4, 10'd0, 10'd0, 24'h0, 8'd0, 5'd3);
        wait_wr(13);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_write", 32'(h2f_write), 0);
        chk("mid_rst_io", h2f_io, 0);
        chk("mid_rst_cnt", 32'(issued_cnt), 0);
        chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_ready", 32'(cmd_ready), 0);
        chk("mid_rst_err", 32'(err_illegal), 0);
        exp_q.delete();
        n_iss = 0;
        last_wr = -1000;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_mid_rst", 32'(cmd_ready), 1);
        repeat (10) @(negedge clk);
        chk("fifo_flushed", 32'(nwr), 13);
        // Randomized traffic against a randomly busy control unit.
        fork
            begin
                repeat (40) begin
                    send_rand(7);
                    repeat ($urandom_range(0, 3)) @(negedge clk);
                end
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    @(negedge clk);
                    isrunning = ($urandom_range(0, 2) == 0);
                end
            end
        join
        isrunning = 1'b0;
        p = 0;
        while (exp_q.size() != 0 && p < 3000) begin
            @(negedge clk);
            p++;
        end
        chk("rand_drained", 32'(exp_q.size()), 0);
        repeat (10) @(negedge clk);
        chk("rand_not_busy", 32'(busy), 0);
        chk("rand_issued_cnt", 32'(issued_cnt), 32'(n_iss));
        chk("rand_err_timeout", 32'(err_timeout), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
